// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_seq_adder_cla_4.sv
// 4-bit carry-lookahead slice: all slice carries come from generate/propagate
// terms in one level of logic rather than rippling.
module CLA_4 (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = X & Y;
  assign p = X ^ Y;

  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign S    = p ^ c[3:0];
  assign Cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Area-reduced WIDTH-bit adder: one shared CLA_4 slice, one nibble per clock,
// LSB first. Define CLA_SEQ_SUB_EN to enable the subtract (req_sub) path.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  input  logic             req_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             busy
);

  localparam int N     = slice_count(WIDTH);
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0]   b_eff;
  logic               cin_eff;
  logic [SLICE_W-1:0] slice_x;
  logic [SLICE_W-1:0] slice_y;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;

`ifdef CLA_SEQ_SUB_EN
  // Two's-complement subtract: A + ~B + 1.
  assign b_eff   = req_sub ? ~req_b : req_b;
  assign cin_eff = req_sub ? 1'b1 : req_cin;
`else
  logic unused_sub;
  assign unused_sub = req_sub;
  assign b_eff      = req_b;
  assign cin_eff    = req_cin;
`endif

  assign slice_x = a_q[SLICE_W*int'(idx) +: SLICE_W];
  assign slice_y = b_q[SLICE_W*int'(idx) +: SLICE_W];

  CLA_4 u_slice (
    .X    (slice_x),
    .Y    (slice_y),
    .Cin  (carry_q),
    .S    (slice_s),
    .Cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= b_eff;
            carry_q <= cin_eff;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[SLICE_W*int'(idx) +: SLICE_W] <= slice_s;
          carry_q <= slice_cout;
          if (idx == IDX_LAST) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign res_sum   = sum_q;
  assign res_cout  = carry_q;
  // b_q already holds the effective B, so this is correct for subtract too.
  assign res_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_cla_seq_adder.sv
// Randomized and directed bench for cla_seq_adder (WIDTH = 32) against an
// arithmetic reference model.
module tb_cla_seq_adder;

  localparam int W   = 32;
  localparam int N   = W / 4;
`ifdef CLA_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_cin = 1'b0;
  logic         req_sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain integer addition.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   t;
    logic         ovf;
    be  = (sub && SUB_EN) ? ~b : b;
    ce  = (sub && SUB_EN) ? 1'b1 : cin;
    t   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
    ovf = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return {ovf, t[W], t[W-1:0]};
  endfunction

  // Issues one request from IDLE and waits (bounded) for res_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output logic [W-1:0] s, output logic co,
                       output logic ov, output int lat);
    req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    s = res_sum; co = res_cout; ov = res_ovf;
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, res_valid, busy, res_cout, res_ovf} !== 5'b10000 || res_sum !== '0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b, want 1 0 0 0 0 0",
               req_ready, res_valid, busy, res_sum, res_cout, res_ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] a_t[5] = '{32'h0000000F, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h5, 32'h80000000};
    logic [W-1:0] b_t[5] = '{32'h00000001, 32'h00000000, 32'h00000001, 32'h7, 32'h80000000};
    logic         c_t[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         s_t[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // Independent constant expectations for the listed cases.
    logic [W-1:0] sum_t[5] = '{32'h00000010, 32'h0, 32'h80000000,
                               SUB_EN ? 32'hFFFFFFFE : 32'h0000000C, 32'h0};
    logic         co_t[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         ov_t[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] s;
    logic         co, ov;
    int           lat;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed_ready[%0d]: got %b want 1", i, req_ready);
      end
      do_op(a_t[i], b_t[i], c_t[i], s_t[i], s, co, ov, lat);
      checks++;
      if (lat !== N) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, N);
      end
      checks++;
      if (s !== sum_t[i] || co !== co_t[i] || ov !== ov_t[i]) begin
        errors++;
        $display("FAIL directed[%0d]: sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, s, co, ov, sum_t[i], co_t[i], ov_t[i]);
      end
      release_res();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic         cin, sub, co, ov;
    logic [W+1:0] exp;
    int           lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      if (i % 4 == 0) b = ~a;
      cin = 1'($urandom); sub = 1'($urandom);
      exp = model(a, b, cin, sub);
      do_op(a, b, cin, sub, s, co, ov, lat);
      checks++;
      if (lat !== N || {ov, co, s} !== exp) begin
        errors++;
        $display("FAIL random[%0d]: a=%h b=%h cin=%b sub=%b got lat=%0d ovf=%b cout=%b sum=%h want lat=%0d ovf=%b cout=%b sum=%h",
                 i, a, b, cin, sub, lat, ov, co, s, N, exp[W+1], exp[W], exp[W-1:0]);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      release_res();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s, s2;
    logic         co, ov, co2, ov2;
    logic [W+1:0] exp;
    int           lat;
    exp = model(32'h89ABCDEF, 32'h76543210, 1'b1, 1'b0);
    do_op(32'h89ABCDEF, 32'h76543210, 1'b1, 1'b0, s, co, ov, lat);
    checks++;
    if ({ov, co, s} !== exp) begin
      errors++;
      $display("FAIL backpressure_result: got %h want %h", {ov, co, s}, exp);
    end
    req_a = 32'h11111111; req_b = 32'h22222222; req_cin = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_sum !== s
          || res_cout !== co || res_ovf !== ov) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: vld=%b rdy=%b sum=%h cout=%b ovf=%b want 1 0 %h %b %b",
                 i, res_valid, req_ready, res_sum, res_cout, res_ovf, s, co, ov);
      end
    end
    req_valid = 1'b0;
    release_res();
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: vld=%b rdy=%b busy=%b want 0 1 0",
               res_valid, req_ready, busy);
    end
    exp = model(32'h00000003, 32'h00000004, 1'b0, 1'b0);
    do_op(32'h00000003, 32'h00000004, 1'b0, 1'b0, s2, co2, ov2, lat);
    checks++;
    if ({ov2, co2, s2} !== exp) begin
      errors++;
      $display("FAIL backpressure_next: got %h want %h", {ov2, co2, s2}, exp);
    end
    release_res();
  endtask

  task automatic test_back_to_back();
    int           acc[$];
    int           cyc = 0;
    logic [W+1:0] exp;
    exp = model(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0);
    req_a = 32'h12345678; req_b = 32'h0FEDCBA9; req_cin = 1'b1; req_sub = 1'b0;
    req_valid = 1'b1; res_ready = 1'b1;
    while (acc.size() < 3 && cyc < 100) begin
      if (req_ready) acc.push_back(cyc);
      @(posedge clk); #1;
      cyc++;
      if (res_valid) begin
        checks++;
        if ({res_ovf, res_cout, res_sum} !== exp) begin
          errors++;
          $display("FAIL b2b_result: got %h want %h", {res_ovf, res_cout, res_sum}, exp);
        end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (acc.size() != 3) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d want 3", acc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc[i] - acc[i-1] != N + 2) begin
          errors++;
          $display("FAIL b2b_period[%0d]: got %0d want %0d", i, acc[i] - acc[i-1], N + 2);
        end
      end
    end
    cyc = 0;
    while (!req_ready && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    res_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain: req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_abort();
    req_a = 32'hFFFFFFFF; req_b = 32'hFFFFFFFF; req_cin = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || res_sum[11:0] !== 12'hFFF) begin
      errors++;
      $display("FAIL abort_midrun: busy=%b sum=%h want busy=1 sum[11:0]=fff", busy, res_sum);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, res_valid, busy, res_cout, res_ovf} !== 5'b10000 || res_sum !== '0) begin
      errors++;
      $display("FAIL abort_reset: rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0 0",
               req_ready, res_valid, busy, res_sum, res_cout, res_ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle wide adder sequencer that shares a single 4-bit carry-lookahead slice across a WIDTH-bit operation, one nibble per clock, least-significant first, with a registered ripple carry between slices. It sits beside the CPU ALU as the area-reduced add/subtract path. Operands enter through a valid/ready request port, and results leave through a valid/ready result port.

## Interface
- WIDTH, 32: operand width in bits. Must be a multiple of 4 and ≥ 8. Slice count N = WIDTH/4.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; equals (state == IDLE).
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_cin  in  1  carry-in (add mode).
- req_sub  in  1  subtract request; honoured only when CLA_SEQ_SUB_EN is defined.
- res_valid  out  1  result held valid; equals (state == DONE).
- res_ready  in  1  consumer accepts result.
- res_sum  out  WIDTH  sum.
- res_cout  out  1  carry out of bit WIDTH-1.
- res_ovf  out  1  signed overflow.
- busy  out  1  (state == RUN).

## Operation
- States: IDLE, RUN, DONE. Registers: a_q, b_q (effective B), carry_q, idx (ceil(log2 N) bits), sum_q, state.
- IDLE: on req_valid && req_ready, latch a_q = req_a and b_q = effective B, set carry_q = effective cin, set idx = 0, and go to RUN.
- RUN, each cycle:
  - The slice adds a_q[4·idx+:4] + b_q[4·idx+:4] + carry_q.
  - The nibble result is written to sum_q[4·idx+:4], and the slice carry-out is stored in carry_q.
  - If idx == N-1, go to DONE; otherwise idx increments.
- DONE: outputs are stable. On res_ready, go to IDLE.
- req_ready stays 0 in the DONE cycle, so no new request is accepted until IDLE.
- res_cout = carry_q.
- res_ovf = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]), using the effective B.
- Width rules:
  - Sum is modulo 2^WIDTH.
  - No sign extension.
  - idx never wraps past N-1.
- req_valid while not in IDLE is ignored; the operands are not sampled.
- res_ready while not in DONE is ignored.

## Timing
- Reset (rst_n = 0 at an edge) takes effect from any state, including mid-RUN.
  - state = IDLE; sum_q, a_q, b_q, idx, carry_q = 0.
  - Resulting outputs: req_ready = 1, res_valid = 0, busy = 0, res_sum = 0, res_cout = 0, res_ovf = 0.
- Latency: with acceptance at edge k, slices 0..N-1 are processed at edges k+1..k+N, and res_valid rises after edge k+N. For WIDTH = 32, that is 8 cycles.
- Throughput: with res_ready held at 1, the block accepts one request every N+2 cycles (accept, N RUN cycles, DONE).
- res_sum, res_cout and res_ovf are constant for the whole time res_valid = 1.
- res_sum may show partial nibbles during RUN; consumers sample only when res_valid = 1.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - req_sub = 1 gives effective B = ~req_b and effective cin = 1, so res_sum = A − B. res_cout = 1 means no borrow.
  - req_sub = 0 gives effective B = req_b and effective cin = req_cin.
- CLA_SEQ_SUB_EN undefined:
  - req_sub is ignored; effective B = req_b and effective cin = req_cin always.
  - No inverter or mux logic is generated.

## Structure
- Package cla_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparam SLICE_W = 4;
  - a function computing N from WIDTH.
- Single sub-module: the team's existing 4-bit lookahead slice CLA_4, instantiated once.
  - Its X, Y and Cin ports take the selected nibbles and carry_q.
  - Its S and Cout ports feed the sum_q/carry_q update.
- Everything else (FSM, index counter, operand registers) is in this module.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles → req_ready = 1, res_valid = 0, busy = 0, res_sum = 0, res_cout = 0.
- Nibble-crossing carry (WIDTH = 32): A = 0x0000000F, B = 0x00000001, cin = 0 → res_sum = 0x00000010, cout = 0, ovf = 0. res_valid rises exactly 8 edges after acceptance.
- Full ripple with cin: A = 0xFFFFFFFF, B = 0x00000000, cin = 1 → res_sum = 0, cout = 1.
- Signed overflow: A = 0x7FFFFFFF, B = 0x00000001 → res_sum = 0x80000000, ovf = 1.
- Subtract (macro on): A = 5, B = 7, req_sub = 1 → res_sum = 0xFFFFFFFE, cout = 0. With the macro off, the same stimulus gives 0x0000000C.
- Backpressure and abort:
  - Hold res_ready = 0 for 5 cycles in DONE → outputs are unchanged and a new req_valid is not accepted.
  - Assert rst_n = 0 at idx = 3 of a later operation → IDLE next cycle with all outputs 0.
